// File: rtl/router_route_unit.sv
// Per-input-port route computation: decodes head-flit destinations into a one-hot
// output-port request (XY or YX dimension order) and holds it for the whole packet.
module router_route_unit #(
  parameter int X_W    = 2,
  parameter int Y_W    = 1,
  parameter int MESH_X = 4,
  parameter int MESH_Y = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           flit_valid,
  input  logic           flit_head,
  input  logic           flit_tail,
  input  logic [X_W-1:0] router_x,
  input  logic [Y_W-1:0] router_y,
  input  logic [X_W-1:0] dst_x,
  input  logic [Y_W-1:0] dst_y,
  input  logic           mode,
  output logic [4:0]     port,
  output logic           route_valid,
  output logic           dst_err,
  output logic           proto_err
);

  localparam logic [4:0] P_LOCAL = 5'b00001;
  localparam logic [4:0] P_X1    = 5'b00010;
  localparam logic [4:0] P_X2    = 5'b00100;
  localparam logic [4:0] P_Y1    = 5'b01000;
  localparam logic [4:0] P_Y2    = 5'b10000;
  localparam logic [31:0] MESH_X_U = 32'(MESH_X);
  localparam logic [31:0] MESH_Y_U = 32'(MESH_Y);

  typedef enum logic [1:0] {IDLE, LOCK, ONE} state_t;

  state_t     state;
  logic       accept;
  logic       dst_oor;
  logic [4:0] x_port;
  logic [4:0] y_port;
  logic [4:0] head_port;

  assign accept = en && flit_valid;

  always_comb begin
    dst_oor   = (32'(dst_x) >= MESH_X_U) || (32'(dst_y) >= MESH_Y_U);
    x_port    = 5'b00000;
    y_port    = 5'b00000;
    head_port = P_LOCAL;
    if (dst_x > router_x)      x_port = P_X2;
    else if (dst_x < router_x) x_port = P_X1;
    if (dst_y > router_y)      y_port = P_Y2;
    else if (dst_y < router_y) y_port = P_Y1;
    // Out-of-range destinations are ejected locally and dropped there.
    if (dst_oor)                head_port = P_LOCAL;
    else if (!mode) begin
      if (x_port != 5'b00000)      head_port = x_port;
      else if (y_port != 5'b00000) head_port = y_port;
    end else begin
      if (y_port != 5'b00000)      head_port = y_port;
      else if (x_port != 5'b00000) head_port = x_port;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      port        <= 5'b00000;
      route_valid <= 1'b0;
      dst_err     <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      dst_err   <= 1'b0;
      proto_err <= 1'b0;
      if (en) begin
        case (state)
          IDLE, ONE: begin
            if (accept && flit_head) begin
              port        <= head_port;
              route_valid <= 1'b1;
              dst_err     <= dst_oor;
              state       <= flit_tail ? ONE : LOCK;
            end else if (accept) begin
              proto_err   <= 1'b1;
              state       <= IDLE;
              port        <= 5'b00000;
              route_valid <= 1'b0;
            end else if (state == ONE) begin
              state       <= IDLE;
              port        <= 5'b00000;
              route_valid <= 1'b0;
            end
          end
          LOCK: begin
            // After the tail the route stays up one more cycle; ONE then
            // either clears it or accepts a back-to-back head.
            if (accept && flit_head)      proto_err <= 1'b1;
            else if (accept && flit_tail) state     <= ONE;
          end
          default: begin
            state       <= IDLE;
            port        <= 5'b00000;
            route_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
